// File: rtl/mu0_bus_pkg.sv
// Shared MU0 bus types and widths, used by the arbiter and by other MU0 bus blocks.
package mu0_bus_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01
    } arb_state_t;

    typedef logic [0:0] master_id_t;

endpackage

// File: rtl/mu0_mem_arbiter_if.sv
// One MU0 master port: the master drives address/strobes/data, the arbiter answers.
// Handshake: the master raises read or write and holds address, writedata and the strobe
// stable; the transaction completes in the first cycle the master samples waitrequest low.
interface mu0_mem_arbiter_if #(
    parameter int ADDR_W = mu0_bus_pkg::ADDR_W,
    parameter int DATA_W = mu0_bus_pkg::DATA_W
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mu0_rr_pick.sv
// Combinational two-way round-robin picker: on contention the master that did not
// complete last wins.
module mu0_rr_pick
    import mu0_bus_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_owner,
    output logic       grant_valid,
    output master_id_t grant_id
);
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_id = ~last_owner;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end else begin
            grant_id = 1'b0;
        end
    end
endmodule

// File: rtl/mu0_mem_arbiter.sv
// Shares one MU0 memory port between two masters with per-transaction round-robin,
// for either a combinational (delay0) or registered (delay1) memory read path.
module mu0_mem_arbiter #(
    parameter string DELAY  = "delay0",
    parameter int    ADDR_W = mu0_bus_pkg::ADDR_W,
    parameter int    DATA_W = mu0_bus_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    mu0_mem_arbiter_if.slave  m0,
    mu0_mem_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              grant_owner,
    output logic              protocol_error,
    output logic [1:0]        dbg_state
);
    import mu0_bus_pkg::*;

    localparam bit REG_RD = (DELAY == "delay1");

    arb_state_t        state, state_n;
    master_id_t        last_owner, lock_owner, lock_owner_n, shown_owner;
    master_id_t        owner, grant_id;
    logic              grant_valid, owner_valid, err_set;
    logic [1:0]        req, complete;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_writedata;
    logic              sel_read, sel_write;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    mu0_rr_pick u_pick (
        .req         (req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // While a registered read is outstanding the owner is locked, not re-picked.
    always_comb begin
        owner         = (state == RD_WAIT) ? lock_owner : grant_id;
        sel_address   = owner[0] ? m1.address   : m0.address;
        sel_writedata = owner[0] ? m1.writedata : m0.writedata;
        sel_read      = owner[0] ? m1.read      : m0.read;
        sel_write     = owner[0] ? m1.write     : m0.write;
    end

    always_comb begin
        state_n       = state;
        lock_owner_n  = lock_owner;
        owner_valid   = 1'b0;
        complete      = 2'b00;
        mem_address   = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = '0;
        err_set       = (m0.read & m0.write) | (m1.read & m1.write);
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    owner_valid   = 1'b1;
                    mem_address   = sel_address;
                    mem_writedata = sel_writedata;
                    if (sel_write) begin
                        mem_write       = 1'b1;
                        complete[owner] = 1'b1;
                    end else begin
                        mem_read = 1'b1;
                        if (REG_RD) begin
                            state_n      = RD_WAIT;
                            lock_owner_n = owner;
                        end else begin
                            complete[owner] = 1'b1;
                        end
                    end
                end
            end
            RD_WAIT: begin
                owner_valid = 1'b1;
                state_n     = IDLE;
                if (sel_read) begin
                    mem_address     = sel_address;
                    mem_read        = 1'b1;
                    complete[owner] = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            default: begin
                err_set = 1'b1;
                state_n = IDLE;
            end
        endcase
        // An in-flight transaction is abandoned by reset, never reported as done.
        if (rst) begin
            complete = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_owner     <= 1'b1;
            lock_owner     <= 1'b0;
            shown_owner    <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state      <= state_n;
            lock_owner <= lock_owner_n;
            if (|complete) begin
                last_owner <= owner;
            end
            if (owner_valid) begin
                shown_owner <= owner;
            end
            if (err_set) begin
                protocol_error <= 1'b1;
            end
        end
    end

    assign grant_owner    = owner_valid ? owner[0] : shown_owner[0];
    assign dbg_state      = state;
    assign m0.readdata    = mem_readdata;
    assign m1.readdata    = mem_readdata;
    assign m0.waitrequest = req[0] & ~complete[0];
    assign m1.waitrequest = req[1] & ~complete[1];
endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Bench for mu0_mem_arbiter: a delay0 and a delay1 instance side by side, driven by a
// table of directed vectors, hand-written reset/error sequences and random traffic.
module tb_mu0_mem_arbiter;

  typedef struct {
    logic        d;
    logic        rs;
    logic        r0, w0;
    logic [11:0] a0;
    logic [15:0] wd0;
    logic        r1, w1;
    logic [11:0] a1;
    logic [15:0] wd1;
    logic        ew0, ew1, erd, ewr;
    logic [11:0] eaddr;
    logic [15:0] ewd;
    logic        egown, eperr;
    logic [1:0]  rdm;
    logic [15:0] erdd;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [11:0] m_addr [2][2];
  logic        m_rd [2][2];
  logic        m_wr [2][2];
  logic [15:0] m_wd [2][2];
  logic [15:0] m_rdata [2][2];
  logic        m_wait [2][2];
  logic [11:0] mem_addr [2];
  logic        mem_rd [2];
  logic        mem_wr [2];
  logic [15:0] mem_wd [2];
  logic [15:0] mem_rdata [2];
  logic        gown [2];
  logic        perr [2];
  logic [1:0]  dbg [2];
  logic [15:0] mem0 [4096];
  logic [15:0] mem1 [4096];
  logic [15:0] rd_q1;
  logic [15:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and buses ----------------
  mu0_mem_arbiter_if bus00 ();
  mu0_mem_arbiter_if bus01 ();
  mu0_mem_arbiter_if bus10 ();
  mu0_mem_arbiter_if bus11 ();

  assign bus00.address = m_addr[0][0];
  assign bus00.read = m_rd[0][0];
  assign bus00.write = m_wr[0][0];
  assign bus00.writedata = m_wd[0][0];
  assign m_rdata[0][0] = bus00.readdata;
  assign m_wait[0][0] = bus00.waitrequest;
  assign bus01.address = m_addr[0][1];
  assign bus01.read = m_rd[0][1];
  assign bus01.write = m_wr[0][1];
  assign bus01.writedata = m_wd[0][1];
  assign m_rdata[0][1] = bus01.readdata;
  assign m_wait[0][1] = bus01.waitrequest;
  assign bus10.address = m_addr[1][0];
  assign bus10.read = m_rd[1][0];
  assign bus10.write = m_wr[1][0];
  assign bus10.writedata = m_wd[1][0];
  assign m_rdata[1][0] = bus10.readdata;
  assign m_wait[1][0] = bus10.waitrequest;
  assign bus11.address = m_addr[1][1];
  assign bus11.read = m_rd[1][1];
  assign bus11.write = m_wr[1][1];
  assign bus11.writedata = m_wd[1][1];
  assign m_rdata[1][1] = bus11.readdata;
  assign m_wait[1][1] = bus11.waitrequest;

  mu0_mem_arbiter #(.DELAY("delay0")) u_d0 (
    .clk(clk), .rst(rst), .m0(bus00), .m1(bus01),
    .mem_address(mem_addr[0]), .mem_read(mem_rd[0]), .mem_write(mem_wr[0]),
    .mem_writedata(mem_wd[0]), .mem_readdata(mem_rdata[0]),
    .grant_owner(gown[0]), .protocol_error(perr[0]), .dbg_state(dbg[0])
  );

  mu0_mem_arbiter #(.DELAY("delay1")) u_d1 (
    .clk(clk), .rst(rst), .m0(bus10), .m1(bus11),
    .mem_address(mem_addr[1]), .mem_read(mem_rd[1]), .mem_write(mem_wr[1]),
    .mem_writedata(mem_wd[1]), .mem_readdata(mem_rdata[1]),
    .grant_owner(gown[1]), .protocol_error(perr[1]), .dbg_state(dbg[1])
  );

  // Memory models: combinational read for delay0, registered read for delay1.
  assign mem_rdata[0] = mem0[mem_addr[0]];
  assign mem_rdata[1] = rd_q1;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem0[i] <= 16'hC000 | 16'(i);
      mem1[i] <= 16'hC000 | 16'(i);
    end
    mem0[5] <= 16'h1234;
  end

  always @(posedge clk) begin
    if (mem_wr[0]) mem0[mem_addr[0]] <= mem_wd[0];
    if (mem_wr[1]) mem1[mem_addr[1]] <= mem_wd[1];
    if (mem_rd[1]) rd_q1 <= mem1[mem_addr[1]];
  end

  // ---------------- driver tasks ----------------
  task automatic set_m(input int d, input int m, input logic r, input logic w,
                       input logic [11:0] a, input logic [15:0] wd);
    m_rd[d][m] = r;
    m_wr[d][m] = w;
    m_addr[d][m] = a;
    m_wd[d][m] = wd;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++)
        set_m(d, m, 1'b0, 1'b0, 12'h0, 16'h0);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    cyc_end();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] getmem(input int d, input int a);
    return (d == 0) ? mem0[a] : mem1[a];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int d, input int rs, input int r0, input int w0,
                              input int a0, input int wd0, input int r1, input int w1,
                              input int a1, input int wd1, input int ew0, input int ew1,
                              input int erd, input int ewr, input int eaddr, input int ewd,
                              input int egown, input int eperr, input int rdm, input int erdd);
    vec_t v;
    v.d = d[0];      v.rs = rs[0];
    v.r0 = r0[0];    v.w0 = w0[0];    v.a0 = a0[11:0];  v.wd0 = wd0[15:0];
    v.r1 = r1[0];    v.w1 = w1[0];    v.a1 = a1[11:0];  v.wd1 = wd1[15:0];
    v.ew0 = ew0[0];  v.ew1 = ew1[0];  v.erd = erd[0];   v.ewr = ewr[0];
    v.eaddr = eaddr[11:0];  v.ewd = ewd[15:0];
    v.egown = egown[0];     v.eperr = eperr[0];
    v.rdm = rdm[1:0];       v.erdd = erdd[15:0];
    return v;
  endfunction

  task automatic apply_vec(input int idx, input vec_t v);
    int d;
    d = int'(v.d);
    idle_all();
    rst = v.rs;
    set_m(d, 0, v.r0, v.w0, v.a0, v.wd0);
    set_m(d, 1, v.r1, v.w1, v.a1, v.wd1);
    @(negedge clk);
    chk($sformatf("v%0d_wait0", idx), m_wait[d][0], v.ew0);
    chk($sformatf("v%0d_wait1", idx), m_wait[d][1], v.ew1);
    chk($sformatf("v%0d_mem_read", idx), mem_rd[d], v.erd);
    chk($sformatf("v%0d_mem_write", idx), mem_wr[d], v.ewr);
    chk($sformatf("v%0d_mem_address", idx), mem_addr[d], v.eaddr);
    chk($sformatf("v%0d_mem_writedata", idx), mem_wd[d], v.ewd);
    chk($sformatf("v%0d_grant_owner", idx), gown[d], v.egown);
    chk($sformatf("v%0d_protocol_error", idx), perr[d], v.eperr);
    if (v.rdm[0]) chk($sformatf("v%0d_readdata0", idx), m_rdata[d][0], v.erdd);
    if (v.rdm[1]) chk($sformatf("v%0d_readdata1", idx), m_rdata[d][1], v.erdd);
    cyc_end();
    rst = 1'b0;
  endtask

  // Random two-master traffic against a reference memory over 0x200..0x20F.
  task automatic run_random(input int d, input int ncyc);
    logic [11:0] ra [2];
    logic [15:0] rw [2];
    logic        act [2];
    logic        isw [2];
    logic        cmp [2];
    int          waitcnt [2];
    int          issued [2];
    int          done [2];
    int          maxw;
    logic [15:0] refm [16];
    for (int i = 0; i < 16; i++) refm[i] = 16'hC200 | 16'(i);
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; isw[m] = 1'b0; ra[m] = 12'h200; rw[m] = 16'h0;
      waitcnt[m] = 0; issued[m] = 0; done[m] = 0;
    end
    maxw = 0;
    for (int cyc = 0; cyc < ncyc + 20; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && cyc < ncyc && $urandom_range(0, 3) != 0) begin
          act[m] = 1'b1;
          isw[m] = 1'($urandom_range(0, 1));
          ra[m] = 12'h200 + 12'($urandom_range(0, 15));
          rw[m] = 16'($urandom);
          issued[m]++;
        end
        set_m(d, m, act[m] & ~isw[m], act[m] & isw[m], ra[m], act[m] & isw[m] ? rw[m] : 16'h0);
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) cmp[m] = act[m] && !m_wait[d][m];
      for (int m = 0; m < 2; m++) begin
        if (cmp[m]) begin
          if (isw[m]) begin
            refm[ra[m][3:0]] = rw[m];
          end else begin
            exp_q.push_back(refm[ra[m][3:0]]);
            chk($sformatf("rnd%0d_m%0d_readdata", d, m), m_rdata[d][m], exp_q.pop_front());
          end
          done[m]++;
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (act[m] && !cmp[m] && cmp[1-m]) begin
          waitcnt[m]++;
          if (waitcnt[m] > maxw) maxw = waitcnt[m];
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (cmp[m]) begin
          act[m] = 1'b0;
          waitcnt[m] = 0;
        end
      end
      cyc_end();
    end
    idle_all();
    for (int m = 0; m < 2; m++)
      chk($sformatf("rnd%0d_m%0d_done_count", d, m), done[m], issued[m]);
    chk($sformatf("rnd%0d_starvation", d), (maxw <= 1), 1);
    for (int i = 0; i < 16; i++)
      chk($sformatf("rnd%0d_mem_%0h", d, 12'h200 + i), getmem(d, 'h200 + i), refm[i]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vt [$];
    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state of both instances
    vt.push_back(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0));
    vt.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0));
    // delay0: both masters write every cycle, grants alternate m0, m1, m0, m1
    vt.push_back(mk(0,0, 0,1,'h100,'hA000, 0,1,'h101,'hB000, 0,1,0,1,'h100,'hA000, 0,0,0,0));
    vt.push_back(mk(0,0, 0,1,'h100,'hA001, 0,1,'h101,'hB000, 1,0,0,1,'h101,'hB000, 1,0,0,0));
    vt.push_back(mk(0,0, 0,1,'h100,'hA001, 0,1,'h101,'hB001, 0,1,0,1,'h100,'hA001, 0,0,0,0));
    vt.push_back(mk(0,0, 0,1,'h100,'hA002, 0,1,'h101,'hB001, 1,0,0,1,'h101,'hB001, 1,0,0,0));
    // delay0: single-cycle reads
    vt.push_back(mk(0,0, 1,0,'h005,0, 0,0,0,0, 0,0,1,0,'h005,0, 0,0,1,'h1234));
    vt.push_back(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0));
    vt.push_back(mk(0,0, 0,0,0,0, 1,0,'h010,0, 0,0,1,0,'h010,0, 1,0,2,'hC010));
    // delay0: read+write together acts as write and raises the sticky error
    vt.push_back(mk(0,0, 0,0,0,0, 1,1,'h0FF,'hBEEF, 0,0,0,1,'h0FF,'hBEEF, 1,0,0,0));
    vt.push_back(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 1,1,0,0));
    vt.push_back(mk(0,0, 0,1,'h030,'h1111, 0,0,0,0, 0,0,0,1,'h030,'h1111, 0,1,0,0));
    vt.push_back(mk(0,1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,1,0,0));
    vt.push_back(mk(0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0));
    // delay1: m0 write and m1 read together, then m1 two-cycle read with m0 stalled
    vt.push_back(mk(1,0, 0,1,'h020,'h7777, 1,0,'h010,0, 0,1,0,1,'h020,'h7777, 0,0,0,0));
    vt.push_back(mk(1,0, 0,1,'h021,'h6666, 1,0,'h010,0, 1,1,1,0,'h010,0, 1,0,0,0));
    vt.push_back(mk(1,0, 0,1,'h021,'h6666, 1,0,'h010,0, 1,0,1,0,'h010,0, 1,0,2,'hC010));
    vt.push_back(mk(1,0, 0,1,'h021,'h6666, 0,0,0,0, 0,0,0,1,'h021,'h6666, 0,0,0,0));
    vt.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0));
    vt.push_back(mk(1,0, 1,0,'h005,0, 0,0,0,0, 1,0,1,0,'h005,0, 0,0,0,0));
    vt.push_back(mk(1,0, 1,0,'h005,0, 0,0,0,0, 0,0,1,0,'h005,0, 0,0,1,'hC005));
    vt.push_back(mk(1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0));

    for (int i = 0; i < vt.size(); i++) apply_vec(i, vt[i]);
    idle_all();

    chk("mem0_100", mem0[12'h100], 16'hA001);
    chk("mem0_101", mem0[12'h101], 16'hB001);
    chk("mem0_0ff", mem0[12'h0FF], 16'hBEEF);
    chk("mem1_020", mem1[12'h020], 16'h7777);
    chk("mem1_021", mem1[12'h021], 16'h6666);

    // delay1: reset while m0 waits in RD_WAIT
    set_m(1, 0, 1'b1, 1'b0, 12'h007, 16'h0);
    @(negedge clk);
    chk("t4_issue_mem_read", mem_rd[1], 1'b1);
    chk("t4_issue_wait0", m_wait[1][0], 1'b1);
    cyc_end();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_state", dbg[1], 2'b01);
    chk("t4_rst_no_complete", m_wait[1][0], 1'b1);
    cyc_end();
    rst = 1'b0;
    idle_all();
    @(negedge clk);
    chk("t4_after_mem_read", mem_rd[1], 1'b0);
    chk("t4_after_grant_owner", gown[1], 1'b0);
    chk("t4_after_state", dbg[1], 2'b00);
    chk("t4_after_perr", perr[1], 1'b0);
    cyc_end();
    set_m(1, 0, 1'b0, 1'b1, 12'h040, 16'h4040);
    set_m(1, 1, 1'b0, 1'b1, 12'h041, 16'h4141);
    @(negedge clk);
    chk("t4_first_wait0", m_wait[1][0], 1'b0);
    chk("t4_first_wait1", m_wait[1][1], 1'b1);
    chk("t4_first_owner", gown[1], 1'b0);
    chk("t4_first_addr", mem_addr[1], 12'h040);
    cyc_end();
    set_m(1, 0, 1'b0, 1'b0, 12'h0, 16'h0);
    @(negedge clk);
    chk("t4_second_wait1", m_wait[1][1], 1'b0);
    chk("t4_second_owner", gown[1], 1'b1);
    cyc_end();
    idle_all();

    // delay1: owner drops its read while in RD_WAIT
    set_m(1, 1, 1'b1, 1'b0, 12'h008, 16'h0);
    @(negedge clk);
    chk("drop_issue_wait1", m_wait[1][1], 1'b1);
    chk("drop_issue_mem_read", mem_rd[1], 1'b1);
    cyc_end();
    idle_all();
    @(negedge clk);
    chk("drop_mem_read", mem_rd[1], 1'b0);
    chk("drop_state", dbg[1], 2'b01);
    chk("drop_perr_before", perr[1], 1'b0);
    cyc_end();
    @(negedge clk);
    chk("drop_perr_after", perr[1], 1'b1);
    chk("drop_state_idle", dbg[1], 2'b00);
    cyc_end();
    do_reset();
    @(negedge clk);
    chk("drop_perr_cleared", perr[1], 1'b0);
    cyc_end();

    run_random(0, 200);
    do_reset();
    run_random(1, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
